// File: rtl/base14_pkg.sv
// Shared constants, entry-state encoding and digit check for the base-14 operand datapath.
// The low two bits of each entry state double as the externally visible slot index.
package base14_pkg;

    localparam int RADIX   = 14;
    localparam int DIGIT_W = 4;

    // DONE shares low bits 2'b11 with GET_A1 so the slot reads 3 once an entry completes.
    typedef enum logic [2:0] {
        GET_B0 = 3'b000,
        GET_B1 = 3'b001,
        GET_A0 = 3'b010,
        GET_A1 = 3'b011,
        DONE   = 3'b111
    } entry_state_e;

    function automatic logic digit_ok(input logic [DIGIT_W-1:0] d);
        return {1'b0, d} < (DIGIT_W+1)'(RADIX);
    endfunction

    function automatic entry_state_e next_state(input entry_state_e s);
        case (s)
            GET_A1:  return GET_A0;
            GET_A0:  return GET_B1;
            GET_B1:  return GET_B0;
            GET_B0:  return DONE;
            default: return GET_A1;
        endcase
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// One-cycle rising-edge detector with synchronous active-low reset; pulse is registered,
// so it appears one clock after the input rise and a held input yields a single pulse.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic in_i,
    output logic pulse_o
);

    logic in_q;
    logic pulse_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_q    <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            in_q    <= in_i;
            pulse_q <= in_i & ~in_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/base14_operand_entry.sv
// Collects A1,A0,B1,B0 base-14 digits one enter press at a time.
// Latency: outputs change 2 clocks after enter rises.
// Backpressure: none; optional ENTRY_TIMEOUT_EN discards an abandoned partial entry after TIMEOUT_CYCLES idle clocks.
module base14_operand_entry
    import base14_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 250000000
)
(
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               enter,
    output logic [DIGIT_W-1:0] A1,
    output logic [DIGIT_W-1:0] A0,
    output logic [DIGIT_W-1:0] B1,
    output logic [DIGIT_W-1:0] B0,
    output logic               operands_valid,
    output logic               entry_err,
    output logic [1:0]         slot
);

    entry_state_e       state_q;
    logic [DIGIT_W-1:0] a1_q, a0_q, b1_q, b0_q;
    logic               valid_q;
    logic               err_q;
    logic               press;
    logic               timeout;

    edge_pulse u_enter_edge (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .in_i    (enter),
        .pulse_o (press)
    );

`ifdef ENTRY_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             counting;

    assign counting = (state_q == GET_A0) || (state_q == GET_B1) || (state_q == GET_B0);
    assign timeout  = counting && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        cnt_d = cnt_q;
        if (!counting || press) begin
            cnt_d = '0;
        end else if (!timeout) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q <= GET_A1;
            a1_q    <= '0;
            a0_q    <= '0;
            b1_q    <= '0;
            b0_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (press) begin
            if (state_q == DONE) begin
                // The press that leaves DONE only restarts entry; its digit is discarded.
                state_q <= GET_A1;
                a1_q    <= '0;
                a0_q    <= '0;
                b1_q    <= '0;
                b0_q    <= '0;
                valid_q <= 1'b0;
            end else if (digit_ok(digit)) begin
                case (state_q)
                    GET_A1:  a1_q <= digit;
                    GET_A0:  a0_q <= digit;
                    GET_B1:  b1_q <= digit;
                    default: b0_q <= digit;
                endcase
                state_q <= next_state(state_q);
                err_q   <= 1'b0;
                if (state_q == GET_B0) begin
                    valid_q <= 1'b1;
                end
            end else begin
                err_q <= 1'b1;
            end
        end else if (timeout) begin
            state_q <= GET_A1;
            a1_q    <= '0;
            a0_q    <= '0;
            b1_q    <= '0;
            b0_q    <= '0;
            err_q   <= 1'b0;
        end
    end

    assign A1             = a1_q;
    assign A0             = a0_q;
    assign B1             = b1_q;
    assign B0             = b0_q;
    assign operands_valid = valid_q;
    assign entry_err      = err_q;
    assign slot           = state_q[1:0];

endmodule

// File: doc/base14_operand_entry.md
Name: base14_operand_entry

Overview:
Upstream operand-capture stage for the two-digit base-14 adder/display datapath. It sequentially collects four digits (A1, A0, B1, B0) from a 4-bit switch field, one per enter-key press, and validates each against the radix. It holds the captured operands stable for the downstream adder and flags completion and entry errors on LEDs.

Parameters:
RADIX, 14, number base; legal digits are 0..RADIX-1.
DIGIT_W, 4, digit width in bits.
TIMEOUT_CYCLES, 250000000, idle cycles before an abandoned partial entry is discarded (optional feature only; 5 s at 50 MHz).

Ports:
CLOCK_50  input  1  system clock; all state on rising edge.
resetn  input  1  synchronous active-low reset.
digit  input  DIGIT_W  candidate digit from switches, sampled only at an accepted enter edge.
enter  input  1  enter request, active-high level (debounced key, already inverted); the block edge-detects it internally.
A1  output  DIGIT_W  operand A, high digit (registered).
A0  output  DIGIT_W  operand A, low digit.
B1  output  DIGIT_W  operand B, high digit.
B0  output  DIGIT_W  operand B, low digit.
operands_valid  output  1  high while all four digits are captured and stable.
entry_err  output  1  sticky flag: last attempted digit was >= RADIX.
slot  output  2  index of the next digit to capture: 3=A1, 2=A0, 1=B1, 0=B0.

Behaviour:
- Reset (resetn=0 at a clock edge): A1=A0=B1=B0=0, operands_valid=0, entry_err=0, slot=3, state=GET_A1, enter edge register=0. Reset has priority over every other event and aborts any entry in progress.
- Edge detect: enter_q is enter delayed one cycle. An accepted press is enter & ~enter_q. A held key produces exactly one press.
- Each press is acted on in the same clock edge in which it is detected. Outputs update one cycle after the enter rising edge is registered, so total latency from the enter rise to the output change is 2 clocks.
- States: GET_A1 -> GET_A0 -> GET_B1 -> GET_B0 -> DONE.
- GET_x on a press with digit < RADIX:
  - Write digit to the slot's register.
  - Clear entry_err.
  - Advance to the next state.
  - Decrement slot (GET_B0 goes to DONE; slot wraps to 3).
- GET_x on a press with digit >= RADIX (14 or 15):
  - Register unchanged, state unchanged.
  - entry_err=1, held until the next accepted digit or reset.
- Entering DONE sets operands_valid=1. A1..B0 then remain constant until a new entry starts.
- DONE on a press:
  - Start a new entry: operands_valid=0, A1..B0 cleared to 0, state=GET_A1, slot=3.
  - The digit value is ignored; that press does not capture a digit.
- No press: all registers hold.
- Partial entries expose their digits on A1..B0 as they are captured, but operands_valid stays 0 until DONE. Downstream must qualify with operands_valid.
- No arithmetic is performed. The digit comparison is unsigned DIGIT_W-bit against RADIX.

Optional Feature:
- Macro ENTRY_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in the states GET_A0, GET_B1 and GET_B0, and restarts on every press.
  - When it reaches TIMEOUT_CYCLES with no press, the partial entry is discarded: A1..B0=0, entry_err=0, state=GET_A1, slot=3.
  - The counter is idle and held at 0 in GET_A1 and DONE.
  - A press arriving in the same cycle as the timeout wins, and the timeout is ignored.
- Undefined: no counter exists, and a partial entry waits indefinitely.

Decomposition:
- Package base14_pkg:
  - Localparams RADIX and DIGIT_W.
  - State enum (GET_A1, GET_A0, GET_B1, GET_B0, DONE) with the slot encoding 3..0.
  - The shared adder stage uses this package for its RADIX constant.
- One natural sub-module, edge_pulse: a one-cycle rising-edge detector with synchronous active-low reset. It is reusable for other KEY inputs.
- The FSM and operand registers stay in the top module.

Test Plan:
- Reset, then press with digits 5, 13, 0, 9 -> A1=5, A0=13, B1=0, B0=9; operands_valid=1 two clocks after the 4th enter rise; slot=3; entry_err=0.
- In GET_A0, press with digit=14 -> entry_err=1, A0 unchanged, slot stays 2; then press with digit 7 -> A0=7, entry_err=0, slot=1.
- Hold enter high for 100 cycles in GET_A1 with digit=3 -> exactly one capture (A1=3), slot=2.
- In DONE with operands 5/13/0/9, press once with digit=15 -> operands_valid=0, all operands 0, slot=3, entry_err stays 0.
- Assert resetn=0 for one clock after two digits are captured -> all outputs return to their reset values; next press captures into A1.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=20, capture A1=4, then idle 20 cycles -> A1=0, slot=3; with a press on cycle 20 -> capture wins and there is no discard.
